// File: rtl/design_switch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : design_switch_sequencer_if
// Brief    : Bundle of select, per-design GPIO/control and routed pad signals
//            exchanged between the switch sequencer and its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface design_switch_sequencer_if #(
    parameter int NUM_DESIGNS = 12,
    parameter int GPIO_W      = 34,
    parameter int SEL_W       = 4
);
    logic [SEL_W-1:0]              design_select;
    logic [NUM_DESIGNS*GPIO_W-1:0] designs_gpio_out;
    logic [NUM_DESIGNS*GPIO_W-1:0] designs_gpio_oeb;
    logic [GPIO_W-1:0]             gpio_out;
    logic [GPIO_W-1:0]             gpio_oeb;
    logic [NUM_DESIGNS-1:0]        designs_cs;
    logic [NUM_DESIGNS-1:0]        designs_n_rst;
    logic [SEL_W-1:0]              active_design;
    logic                          busy;

    // Environment side: drives the request and the designs' pad outputs.
    modport master (
        output design_select, designs_gpio_out, designs_gpio_oeb,
        input  gpio_out, gpio_oeb, designs_cs, designs_n_rst, active_design, busy
    );

    // Sequencer side.
    modport slave (
        input  design_select, designs_gpio_out, designs_gpio_oeb,
        output gpio_out, gpio_oeb, designs_cs, designs_n_rst, active_design, busy
    );
endinterface
`default_nettype wire

// File: rtl/design_switch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : design_switch_sequencer
// Brief    : Routes the pads to one of NUM_DESIGNS designs. Switching first
//            parks the pads in input mode (GUARD), then holds the incoming
//            design in reset with chip select asserted (RESET), then runs it.
// Revision : 1.0 - initial release
// ============================================================================
module design_switch_sequencer #(
    parameter int NUM_DESIGNS  = 12,
    parameter int GPIO_W       = 34,
    parameter int SEL_W        = 4,
    parameter int GUARD_CYCLES = 4,
    parameter int RST_CYCLES   = 8
) (
    input  wire logic                   clk,
    input  wire logic                   n_rst,
    design_switch_sequencer_if.slave    bus
);
    localparam int MAX_CYCLES = (GUARD_CYCLES > RST_CYCLES) ? GUARD_CYCLES : RST_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // Counters load "cycles - 1" on entry and the state exits when they hit 0.
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYCLES - 1);
    localparam logic [SEL_W-1:0] MAX_SEL    = SEL_W'(NUM_DESIGNS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_GUARD = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] tgt, tgt_nxt;
    logic [SEL_W-1:0] pending, pending_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accepted;
    logic             sel_valid;
    logic             pending_valid;

    // A request counts only once the select has been stable for two samples.
    assign accepted      = (bus.design_select == sel_q);
    assign sel_valid     = (sel_q != '0) && (sel_q <= MAX_SEL);
    assign pending_valid = (pending != '0) && (pending <= MAX_SEL);

    // State, target, pending request, select sample and cycle counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= ST_IDLE;
            tgt     <= '0;
            sel_q   <= '0;
            pending <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            tgt     <= tgt_nxt;
            sel_q   <= bus.design_select;
            pending <= pending_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // Next-state logic; the counter saturates at zero instead of wrapping.
    always_comb begin
        state_nxt   = state;
        tgt_nxt     = tgt;
        pending_nxt = pending;
        cnt_nxt     = (cnt != '0) ? (cnt - CNT_W'(1)) : '0;
        case (state)
            ST_IDLE: begin
                if (accepted && sel_valid) begin
                    tgt_nxt   = sel_q;
                    cnt_nxt   = RST_LOAD;
                    state_nxt = ST_RESET;
                end
            end
            ST_RESET: begin
                if (cnt == '0) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // Any different value, including 0 or out-of-range, leaves the
                // running design; validity is decided at the end of GUARD.
                if (accepted && (sel_q != tgt)) begin
                    pending_nxt = sel_q;
                    cnt_nxt     = GUARD_LOAD;
                    state_nxt   = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (cnt == '0) begin
                    if (pending_valid) begin
                        tgt_nxt   = pending;
                        cnt_nxt   = RST_LOAD;
                        state_nxt = ST_RESET;
                    end else begin
                        tgt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tgt_nxt   = '0;
            end
        endcase
    end

    // Output decode; indices are only formed for designs that match tgt, so
    // an out-of-range target can never select a slice.
    always_comb begin
        bus.gpio_out      = '0;
        bus.gpio_oeb      = '1;
        bus.designs_cs    = '1;
        bus.designs_n_rst = '0;
        bus.active_design = '0;
        bus.busy          = (state == ST_GUARD) || (state == ST_RESET);
        for (int k = 0; k < NUM_DESIGNS; k++) begin
            if (tgt == SEL_W'(k + 1)) begin
                if ((state == ST_RESET) || (state == ST_RUN)) begin
                    bus.designs_cs[k] = 1'b0;
                end
                if (state == ST_RUN) begin
                    bus.designs_n_rst[k] = 1'b1;
                    bus.gpio_out         = bus.designs_gpio_out[k*GPIO_W +: GPIO_W];
                    bus.gpio_oeb         = bus.designs_gpio_oeb[k*GPIO_W +: GPIO_W];
                    bus.active_design    = tgt;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_design_switch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_design_switch_sequencer
// Brief    : Directed, self-checking bench for design_switch_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_design_switch_sequencer;
    localparam int NUM_DESIGNS  = 12;
    localparam int GPIO_W       = 34;
    localparam int SEL_W        = 4;
    localparam int GUARD_CYCLES = 4;
    localparam int RST_CYCLES   = 8;

    logic clk;
    logic n_rst;
    int   n_checks;
    int   n_fail;

    design_switch_sequencer_if #(
        .NUM_DESIGNS (NUM_DESIGNS),
        .GPIO_W      (GPIO_W),
        .SEL_W       (SEL_W)
    ) bif ();

    design_switch_sequencer #(
        .NUM_DESIGNS  (NUM_DESIGNS),
        .GPIO_W       (GPIO_W),
        .SEL_W        (SEL_W),
        .GUARD_CYCLES (GUARD_CYCLES),
        .RST_CYCLES   (RST_CYCLES)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinct per-design pad patterns so misrouting is visible.
    function automatic logic [GPIO_W-1:0] pat_out(input int k);
        logic [63:0] t;
        t = 64'h9E37_79B9_7F4A_7C15 * 64'(k);
        return t[GPIO_W-1:0];
    endfunction

    function automatic logic [GPIO_W-1:0] pat_oeb(input int k);
        logic [63:0] t;
        t = 64'hC2B2_AE3D_27D4_EB4F * 64'(k + 5);
        return t[GPIO_W-1:0];
    endfunction

    task automatic cmp(input string name, input string field, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h at %0t", name, field, act, exp, $time);
        end
    endtask

    // Expected outputs: cs_d / nrst_d / route are design numbers, 0 = none.
    task automatic chk(input string name, input int act, input bit bsy,
                       input int cs_d, input int nrst_d, input int route);
        logic [NUM_DESIGNS-1:0] e_cs;
        logic [NUM_DESIGNS-1:0] e_nrst;
        logic [GPIO_W-1:0]      e_out;
        logic [GPIO_W-1:0]      e_oeb;
        e_cs = '1;
        if (cs_d != 0) e_cs[cs_d-1] = 1'b0;
        e_nrst = '0;
        if (nrst_d != 0) e_nrst[nrst_d-1] = 1'b1;
        if (route != 0) begin
            e_out = pat_out(route);
            e_oeb = pat_oeb(route);
        end else begin
            e_out = '0;
            e_oeb = '1;
        end
        cmp(name, "active_design", 64'(bif.active_design), 64'(act));
        cmp(name, "busy",          64'(bif.busy),          64'(bsy));
        cmp(name, "designs_cs",    64'(bif.designs_cs),    64'(e_cs));
        cmp(name, "designs_n_rst", 64'(bif.designs_n_rst), 64'(e_nrst));
        cmp(name, "gpio_out",      64'(bif.gpio_out),      64'(e_out));
        cmp(name, "gpio_oeb",      64'(bif.gpio_oeb),      64'(e_oeb));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycles(input int n, input string name, input int act, input bit bsy,
                                 input int cs_d, input int nrst_d, input int route);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s[%0d]", name, i), act, bsy, cs_d, nrst_d, route);
        end
    endtask

    // Standard sequences in terms of observable phases.
    task automatic exp_idle(input int n, input string name);
        expect_cycles(n, name, 0, 1'b0, 0, 0, 0);
    endtask
    task automatic exp_guard(input string name);
        expect_cycles(GUARD_CYCLES, name, 0, 1'b1, 0, 0, 0);
    endtask
    task automatic exp_reset(input int n, input int d, input string name);
        expect_cycles(n, name, 0, 1'b1, d, 0, 0);
    endtask
    task automatic exp_run(input int n, input int d, input string name);
        expect_cycles(n, name, d, 1'b0, d, d, d);
    endtask

    typedef struct {
        bit               rst_n;
        logic [SEL_W-1:0] sel;
        int               act;
        bit               bsy;
        int               cs_d;
        int               nrst_d;
        int               route;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_rst    = 1'b0;
        bif.design_select = 4'd3;
        for (int k = 1; k <= NUM_DESIGNS; k++) begin
            bif.designs_gpio_out[(k-1)*GPIO_W +: GPIO_W] = pat_out(k);
            bif.designs_gpio_oeb[(k-1)*GPIO_W +: GPIO_W] = pat_oeb(k);
        end

        // Power-up table: select 3 held through reset release.
        vecs[0] = '{1'b0, 4'd3, 0, 1'b0, 0, 0, 0};
        vecs[1] = '{1'b0, 4'd3, 0, 1'b0, 0, 0, 0};
        vecs[2] = '{1'b1, 4'd3, 0, 1'b0, 0, 0, 0};          // edge 1: IDLE
        for (int i = 3; i <= 10; i++)
            vecs[i] = '{1'b1, 4'd3, 0, 1'b1, 3, 0, 0};      // edges 2-9: RESET 3
        vecs[11] = '{1'b1, 4'd3, 3, 1'b0, 3, 3, 3};         // edge 10: RUN 3
        vecs[12] = '{1'b1, 4'd3, 3, 1'b0, 3, 3, 3};

        for (int i = 0; i < 13; i++) begin
            n_rst             = vecs[i].rst_n;
            bif.design_select = vecs[i].sel;
            tick();
            chk($sformatf("pwr%0d", i), vecs[i].act, vecs[i].bsy,
                vecs[i].cs_d, vecs[i].nrst_d, vecs[i].route);
        end

        // One-cycle glitch to 5 while running 3 is ignored.
        bif.design_select = 4'd5;
        tick();
        chk("glitch0", 3, 1'b0, 3, 3, 3);
        bif.design_select = 4'd3;
        exp_run(3, 3, "glitch");

        // Switch 3 -> 7.
        bif.design_select = 4'd7;
        exp_run(1, 3, "sw7_pre");
        exp_guard("sw7_guard");
        exp_reset(RST_CYCLES, 7, "sw7_reset");
        exp_run(2, 7, "sw7_run");

        // Switch 7 -> 2, then request 9 mid-RESET.
        bif.design_select = 4'd2;
        exp_run(1, 7, "sw2_pre");
        exp_guard("sw2_guard");
        exp_reset(3, 2, "sw2_reset_a");
        bif.design_select = 4'd9;
        exp_reset(RST_CYCLES - 3, 2, "sw2_reset_b");
        exp_run(1, 2, "sw2_run");
        exp_guard("sw9_guard");
        exp_reset(RST_CYCLES, 9, "sw9_reset");
        exp_run(2, 9, "sw9_run");

        // Deselect.
        bif.design_select = 4'd0;
        exp_run(1, 9, "desel_pre");
        exp_guard("desel_guard");
        exp_idle(3, "desel_idle");

        // Invalid selects from IDLE.
        bif.design_select = 4'd13;
        exp_idle(4, "inv13_idle");
        bif.design_select = 4'd15;
        exp_idle(3, "inv15_idle");

        // Bring up 4, then invalid 13 from RUN.
        bif.design_select = 4'd4;
        exp_idle(1, "up4_idle");
        exp_reset(RST_CYCLES, 4, "up4_reset");
        exp_run(1, 4, "up4_run");
        bif.design_select = 4'd13;
        exp_run(1, 4, "inv_run_pre");
        exp_guard("inv_run_guard");
        exp_idle(2, "inv_run_idle");

        // Reset asserted mid-RESET of design 6.
        bif.design_select = 4'd6;
        exp_idle(1, "up6_idle");
        exp_reset(3, 6, "up6_reset");
        n_rst             = 1'b0;
        bif.design_select = 4'd2;
        #1;
        chk("midrst_async", 0, 1'b0, 0, 0, 0);
        tick();
        chk("midrst_held", 0, 1'b0, 0, 0, 0);
        n_rst = 1'b1;
        exp_idle(1, "rst2_idle");
        exp_reset(RST_CYCLES, 2, "rst2_reset");
        exp_run(2, 2, "rst2_run");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
